counter_mod_n: RTL and testbench
================================

// Module: counter_mod_n
// PURPOSE
//  Parametrised modulo-N synchronous up/down counter; successor to the fixed 2-bit counter.
//  Adds the following features:
//   - programmable width and modulus
//   - count enable
//   - cascade carry-in
//   - direction control
//   - synchronous parallel load
//  Sits in the LaunchPad timing/sequencing path (step counters, BCD digits, cascaded prescalers).
//  Multiple instances chain via CI/CR into multi-digit counters.
// PARAMETERS
//  WIDTH    4   counter register width in bits; legal 1..16
//  MODULO   10  count modulus; legal 2..2**WIDTH; VAL ranges 0..MODULO-1
//  RST_VAL  0   value VAL takes on reset; must be < MODULO
// PORTS
//  CLK    in   1      clock, all state on rising edge
//  RST    in   1      asynchronous reset, active-low
//  EN     in   1      count enable
//  CI     in   1      cascade carry-in; a count step occurs only when EN & CI (tie 1 if unused)
//  UP     in   1      direction: 1 = increment, 0 = decrement
//  LD     in   1      synchronous load strobe
//  DIN    in   WIDTH  load value
//  VAL    out  WIDTH  current count (registered)
//  TC     out  1      terminal count, combinational
//                     UP=1: VAL==MODULO-1; UP=0: VAL==0
//  CR     out  1      cascade carry/borrow-out = TC & EN & CI & ~LD, combinational
//  WRAP   out  1      registered 1-cycle pulse, high the cycle after VAL wrapped
//  LDERR  out  1      registered 1-cycle pulse, high the cycle after a load with DIN >= MODULO
// BEHAVIOUR
//  - Reset (RST=0, async, no clock needed): VAL=RST_VAL, WRAP=0, LDERR=0.
//    TC and CR follow VAL/inputs combinationally even while in reset.
//    Reset release is synchronous to the next CLK edge; the first count occurs no earlier than the edge after release.
//  - Per rising edge, priority order:
//    1. LD=1: VAL <= (DIN<MODULO) ? DIN : MODULO-1; LDERR <= (DIN>=MODULO); WRAP <= 0.
//       Load ignores EN, CI and UP.
//    2. else EN&CI&UP:  VAL <= (VAL==MODULO-1) ? 0 : VAL+1; WRAP <= (VAL==MODULO-1).
//    3. else EN&CI&~UP: VAL <= (VAL==0) ? MODULO-1 : VAL-1; WRAP <= (VAL==0).
//    4. else: VAL holds; WRAP <= 0; LDERR <= 0.
//  - LDERR is 0 on every non-load cycle; WRAP is 0 on every non-wrapping cycle.
//  - Latency: VAL updates 1 cycle after the qualifying edge; WRAP/LDERR align with the updated VAL.
//  - CR is combinational so a chain of N stages steps in the same edge (ripple-enable cascade).
//    Downstream stage: CI=upstream CR, with EN and UP shared across the chain.
//  - Direction change mid-count takes effect on the very next step; there is no pipeline to flush.
//  - VAL never leaves 0..MODULO-1 after reset or any load.
//    If VAL is somehow >= MODULO (e.g. X-injection), the next up step forces 0 and the next down step forces MODULO-1.
//  - MODULO==2**WIDTH: wrap is natural binary overflow; arithmetic is done in WIDTH+1 bits, then truncated.
//  - Async reset asserted mid-count or mid-load: VAL=RST_VAL immediately; the in-flight load is lost.
//  - No internal FSM beyond the count register; TC/CR contain no registers.
// TESTING (WIDTH=4, MODULO=10, RST_VAL=0)
//  1. RST=0 then release, EN=CI=UP=1 for 12 clocks.
//     -> VAL 0,1..9,0,1; WRAP high only the cycle VAL=0 after 9; CR=1 only while VAL=9.
//  2. UP=0, EN=CI=1 from VAL=0 for 3 clocks.
//     -> VAL 9,8,7; WRAP pulses once when VAL becomes 9; TC=1 at VAL=0, CR=1 at VAL=0.
//  3. LD=1 DIN=7 with EN=0 -> VAL=7, LDERR=0.
//     LD=1 DIN=13 -> VAL=9, LDERR=1 for exactly 1 cycle.
//     LD=1 together with EN=CI=1 at VAL=9 -> load wins, no WRAP, CR=0.
//  4. Two instances cascaded (ones.CR -> tens.CI), EN=UP=1, run 100 clocks from 00.
//     -> sequence 00..99, then 00; tens steps only on the edge where ones goes 9->0.
//  5. Pull RST low asynchronously mid-count at VAL=5, between clock edges.
//     -> VAL=0 before the next edge; hold RST low 3 edges -> VAL stays 0.
//     Release -> counting resumes 1,2,...
//  6. EN=1, CI toggling 1,0,1,0 -> VAL advances every other cycle.
//     EN=0, CI=1 -> VAL holds, CR=0 even at VAL=9.

Source files
------------

// File: rtl/counter_mod_n.sv
`default_nettype none
// ============================================================================
// Module   : counter_mod_n
// Brief    : Modulo-N up/down counter with enable, cascade carry, and parallel load.
// Revision : 1.0 - initial release
// ============================================================================
module counter_mod_n #(
  parameter int WIDTH   = 4,
  parameter int MODULO  = 10,
  parameter int RST_VAL = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_ci,
  input  logic             i_up,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_val,
  output logic             o_tc,
  output logic             o_cr,
  output logic             o_wrap,
  output logic             o_lderr
);

  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   C_MOD  = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] C_RST  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_val;
  logic             r_wrap;
  logic             r_lderr;

  logic             w_step;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_din_ok;
  logic [WIDTH-1:0] w_val_nxt;
  logic             w_wrap_nxt;
  logic             w_lderr_nxt;

  assign w_step    = i_en & i_ci;
  assign w_at_max  = (r_val == C_MAX);
  assign w_at_zero = (r_val == C_ZERO);
  assign w_din_ok  = ({1'b0, i_din} < C_MOD);

  assign o_tc = i_up ? w_at_max : w_at_zero;
  assign o_cr = o_tc & w_step & ~i_ld;

  // Out-of-range values (>= MODULO) are steered back into range on the next step.
  always_comb begin
    w_val_nxt   = r_val;
    w_wrap_nxt  = 1'b0;
    w_lderr_nxt = 1'b0;
    if (i_ld) begin
      w_val_nxt   = w_din_ok ? i_din : C_MAX;
      w_lderr_nxt = ~w_din_ok;
    end else if (w_step && i_up) begin
      w_wrap_nxt = w_at_max;
      if (r_val >= C_MAX) begin
        w_val_nxt = C_ZERO;
      end else begin
        w_val_nxt = r_val + C_ONE;
      end
    end else if (w_step) begin
      w_wrap_nxt = w_at_zero;
      if (w_at_zero || (r_val > C_MAX)) begin
        w_val_nxt = C_MAX;
      end else begin
        w_val_nxt = r_val - C_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_val   <= C_RST;
      r_wrap  <= 1'b0;
      r_lderr <= 1'b0;
    end else begin
      r_val   <= w_val_nxt;
      r_wrap  <= w_wrap_nxt;
      r_lderr <= w_lderr_nxt;
    end
  end

  assign o_val   = r_val;
  assign o_wrap  = r_wrap;
  assign o_lderr = r_lderr;

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_mod_n
// Brief    : Directed bench for counter_mod_n; ones/tens pair for cascade runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_mod_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, ci, up, ld;
  logic [3:0] din;
  logic [3:0] val, val_t;
  logic       tc, cr, wrap, lderr;
  logic       tc_t, cr_t, wrap_t, lderr_t;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  counter_mod_n #(.WIDTH(4), .MODULO(10), .RST_VAL(0)) u_ones (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_ci(ci), .i_up(up), .i_ld(ld),
    .i_din(din), .o_val(val), .o_tc(tc), .o_cr(cr), .o_wrap(wrap), .o_lderr(lderr)
  );

  counter_mod_n #(.WIDTH(4), .MODULO(10), .RST_VAL(0)) u_tens (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_ci(cr), .i_up(up), .i_ld(1'b0),
    .i_din(4'd0), .o_val(val_t), .o_tc(tc_t), .o_cr(cr_t), .o_wrap(wrap_t),
    .o_lderr(lderr_t)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; ci = 1'b1; up = 1'b1; ld = 1'b0; din = 4'd0;

    // 1: reset state, then count up through the wrap
    step();
    check("rst_val", val, 0);
    check("rst_wrap", wrap, 0);
    check("rst_lderr", lderr, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      check("t1_cr", cr, ((i - 1) % 10) == 9);
      step();
      check("t1_val", val, i % 10);
      check("t1_wrap", wrap, i == 10);
    end

    ld = 1'b1; din = 4'd0;
    step();
    ld = 1'b0;
    check("ld0_val", val, 0);

    // 2: count down from 0
    up = 1'b0;
    #1;
    check("t2_tc0", tc, 1);
    check("t2_cr0", cr, 1);
    step();
    check("t2_val9", val, 9);
    check("t2_wrap9", wrap, 1);
    check("t2_tc9", tc, 0);
    step();
    check("t2_val8", val, 8);
    check("t2_wrap8", wrap, 0);
    step();
    check("t2_val7", val, 7);

    // 3: loads, clamping, load priority
    en = 1'b0; ld = 1'b1; din = 4'd7;
    step();
    check("t3_ld7", val, 7);
    check("t3_lderr7", lderr, 0);
    din = 4'd13;
    step();
    check("t3_ld13", val, 9);
    check("t3_lderr13", lderr, 1);
    din = 4'd10;
    step();
    check("t3_ld10", val, 9);
    check("t3_lderr10", lderr, 1);
    din = 4'd9;
    step();
    check("t3_ld9", val, 9);
    check("t3_lderr9", lderr, 0);
    din = 4'd13;
    step();
    ld = 1'b0;
    step();
    check("t3_hold", val, 9);
    check("t3_lderr_clr", lderr, 0);
    up = 1'b1; en = 1'b1; ci = 1'b1; ld = 1'b1; din = 4'd3;
    #1;
    check("t3_pri_tc", tc, 1);
    check("t3_pri_cr", cr, 0);
    step();
    ld = 1'b0;
    check("t3_pri_val", val, 3);
    check("t3_pri_wrap", wrap, 0);

    // 4: two-digit cascade 00..99, 00
    rst_n = 1'b0;
    #1;
    check("t4_rst", val_t * 10 + val, 0);
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      check("t4_cnt", val_t * 10 + val, k % 100);
    end
    check("t4_tens_wrap", wrap_t, 1);

    // 5: async reset mid-count
    repeat (5) step();
    check("t5_pre", val, 5);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async", val, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_held", val, 0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("t5_resume", val, i);
    end

    // 6: carry-in gating, then enable off at terminal count
    ci = 1'b1; step(); check("t6_ci1a", val, 4);
    ci = 1'b0; step(); check("t6_ci0a", val, 4);
    ci = 1'b1; step(); check("t6_ci1b", val, 5);
    ci = 1'b0; step(); check("t6_ci0b", val, 5);
    ld = 1'b1; din = 4'd9;
    step();
    ld = 1'b0; en = 1'b0; ci = 1'b1;
    #1;
    check("t6_tc", tc, 1);
    check("t6_cr_en0", cr, 0);
    step();
    check("t6_hold9", val, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
